// File: rtl/dispense_pkg.sv
// Shared types, drink codes and recipe table for the dispense sequencer.
// Helper functions cover selection decode and step ordering.
package dispense_pkg;

    localparam int unsigned DUR_W      = 3;
    localparam int unsigned NUM_DRINKS = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AGUA   = 3'd1,
        S_CAFE   = 3'd2,
        S_CHOC   = 3'd3,
        S_LECHE  = 3'd4,
        S_AZUCAR = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [3:0] SEL_ESPRESSO  = 4'b0001;
    localparam logic [3:0] SEL_LATTE     = 4'b0010;
    localparam logic [3:0] SEL_CHOCOLATE = 4'b0100;
    localparam logic [3:0] SEL_MOCCA     = 4'b1000;

    typedef struct packed {
        logic [DUR_W-1:0] agua;
        logic [DUR_W-1:0] cafe;
        logic [DUR_W-1:0] choc;
        logic [DUR_W-1:0] leche;
        logic [DUR_W-1:0] azucar;
    } recipe_t;

    // Seconds per step, indexed by the one-hot bit position of sel.
    localparam recipe_t RECIPES [NUM_DRINKS] = '{
        '{agua: 3'd2, cafe: 3'd2, choc: 3'd0, leche: 3'd0, azucar: 3'd1},
        '{agua: 3'd1, cafe: 3'd2, choc: 3'd0, leche: 3'd2, azucar: 3'd1},
        '{agua: 3'd1, cafe: 3'd0, choc: 3'd3, leche: 3'd2, azucar: 3'd1},
        '{agua: 3'd1, cafe: 3'd1, choc: 3'd1, leche: 3'd1, azucar: 3'd1}
    };

    function automatic logic onehot_ok(input logic [3:0] s);
        return $onehot(s);
    endfunction

    function automatic recipe_t recipe_for(input logic [3:0] s);
        recipe_t r;
        r = '0;
        case (s)
            SEL_ESPRESSO:  r = RECIPES[0];
            SEL_LATTE:     r = RECIPES[1];
            SEL_CHOCOLATE: r = RECIPES[2];
            SEL_MOCCA:     r = RECIPES[3];
            default:       r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_step(input state_t s);
        return (s >= S_AGUA) && (s <= S_AZUCAR);
    endfunction

    function automatic logic [DUR_W-1:0] dur_of(input recipe_t r, input state_t s);
        logic [DUR_W-1:0] d;
        d = '0;
        case (s)
            S_AGUA:   d = r.agua;
            S_CAFE:   d = r.cafe;
            S_CHOC:   d = r.choc;
            S_LECHE:  d = r.leche;
            S_AZUCAR: d = r.azucar;
            default:  d = '0;
        endcase
        return d;
    endfunction

    // First step after cur with a non-zero duration; DONE when none remain.
    function automatic state_t next_step(input recipe_t r, input state_t cur);
        state_t nxt;
        nxt = S_DONE;
        for (int i = 5; i >= 1; i--) begin
            if ((3'(i) > cur) && (dur_of(r, state_t'(3'(i))) != '0)) begin
                nxt = state_t'(3'(i));
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step timer: sub-second tick counter plus whole-seconds-left down-counter.
// expired flags the final tick of the step.
module step_timer #(
    parameter int unsigned TICKS_PER_SEC = 4,
    parameter int unsigned SEC_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [SEC_W-1:0] dur,
    output logic [SEC_W-1:0] secs_left,
    output logic             expired
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] tick;
    logic             second_end;

    assign second_end = (tick == LAST_TICK);
    assign expired    = second_end && (secs_left == SEC_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tick      <= '0;
            secs_left <= '0;
        end else if (load) begin
            tick      <= '0;
            secs_left <= dur;
        end else if (second_end) begin
            tick      <= '0;
            secs_left <= secs_left - SEC_W'(1);
        end else begin
            tick      <= tick + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// Runs the fixed-order valve recipe for a paid drink selection.
// Valve, status and pulse outputs are registered from the next state.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned SEC_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             bad_sel,
    output logic             agua,
    output logic             cafe,
    output logic             chocolate,
    output logic             leche,
    output logic             azucar,
    output logic [SEC_W-1:0] secs_left,
    output logic [2:0]       state
);

    state_t  state_q, state_d;
    recipe_t recipe_q, recipe_sel, recipe_cur;
    logic    start_ok, in_step, entering, expired;
    logic    busy_d, done_d, aborted_d, bad_sel_d;
    logic    agua_d, cafe_d, chocolate_d, leche_d, azucar_d;

    assign recipe_sel = recipe_for(sel);
    assign start_ok   = start && onehot_ok(sel);
    assign in_step    = is_step(state_q);
    // In IDLE the recipe is not latched yet, so plan from the live selection.
    assign recipe_cur = (state_q == S_IDLE) ? recipe_sel : recipe_q;
    assign entering   = is_step(state_d) && (state_d != state_q);
    assign state      = state_q;

    step_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .SEC_W         (SEC_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (entering),
        .clear     (!is_step(state_d)),
        .dur       (SEC_W'(dur_of(recipe_cur, state_d))),
        .secs_left (secs_left),
        .expired   (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            recipe_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start_ok) begin
                recipe_q <= recipe_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = next_step(recipe_cur, S_IDLE);
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (!in_step || cancel) state_d = S_IDLE;
                else if (expired)       state_d = next_step(recipe_cur, state_q);
            end
        endcase
    end

    always_comb begin
        agua_d      = (state_d == S_AGUA);
        cafe_d      = (state_d == S_CAFE);
        chocolate_d = (state_d == S_CHOC);
        leche_d     = (state_d == S_LECHE);
        azucar_d    = (state_d == S_AZUCAR);
        busy_d      = is_step(state_d) || (state_d == S_DONE);
        done_d      = (state_d == S_DONE);
        aborted_d   = in_step && cancel;
        bad_sel_d   = (state_q == S_IDLE) && start && !onehot_ok(sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {agua, cafe, chocolate, leche, azucar} <= '0;
            {busy, done, aborted, bad_sel}         <= '0;
        end else begin
            agua      <= agua_d;
            cafe      <= cafe_d;
            chocolate <= chocolate_d;
            leche     <= leche_d;
            azucar    <= azucar_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
            bad_sel   <= bad_sel_d;
        end
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: per-cycle traces from a timeline model of the recipes,
// directed scenarios plus randomized recipe/cancel/restart runs.
module tb_dispense_sequencer;

    localparam int unsigned TPS = 4;

    logic       clk = 1'b0;
    logic       reset, start, cancel;
    logic [3:0] sel;
    logic       busy, done, aborted, bad_sel;
    logic       agua, cafe, chocolate, leche, azucar;
    logic [2:0] secs_left;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    // Recipe seconds agua/cafe/choc/leche/azucar for espresso, latte, chocolate, mocca.
    int rec [4][5] = '{'{2, 2, 0, 0, 1}, '{1, 2, 0, 2, 1}, '{1, 0, 3, 2, 1}, '{1, 1, 1, 1, 1}};
    logic [14:0] exp_q[$];

    dispense_sequencer #(.TICKS_PER_SEC(TPS), .SEC_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .cancel(cancel),
        .busy(busy), .done(done), .aborted(aborted), .bad_sel(bad_sel),
        .agua(agua), .cafe(cafe), .chocolate(chocolate), .leche(leche), .azucar(azucar),
        .secs_left(secs_left), .state(state)
    );

    always #5 clk = ~clk;

    // {state, valves(bit0=agua..bit4=azucar), secs_left, busy, done, aborted, bad_sel}
    function automatic logic [14:0] pack(int st, int vmask, int secs, bit b, bit d, bit a, bit bs);
        return {3'(st), 5'(vmask), 3'(secs), b, d, a, bs};
    endfunction

    function automatic logic [14:0] observed();
        return {state, azucar, leche, chocolate, cafe, agua, secs_left, busy, done, aborted, bad_sel};
    endfunction

    function automatic int total_cycles(int ri);
        int t = 0;
        for (int i = 0; i < 5; i++) t += rec[ri][i] * TPS;
        return t;
    endfunction

    // Expected outputs for cycles 1.. after the start cycle, ending with one quiet idle cycle.
    task automatic build_trace(input int ri, input int cancel_at);
        int cyc = 0;
        bit cut = 0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < rec[ri][i] * TPS; k++) begin
                if (!cut) begin
                    cyc++;
                    exp_q.push_back(pack(i + 1, 1 << i, rec[ri][i] - k / TPS, 1, 0, 0, 0));
                    if (cyc == cancel_at) cut = 1;
                end
            end
        end
        if (cut) exp_q.push_back(pack(0, 0, 0, 0, 0, 1, 0));
        else     exp_q.push_back(pack(6, 0, 0, 1, 1, 0, 0));
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_recipe(input string name, input int ri, input logic [3:0] start_sel,
                              input int cancel_at, input bit cancel0, input int restart_at,
                              input logic [3:0] restart_sel, input bit scramble);
        build_trace(ri, cancel_at);
        @(negedge clk);
        start = 1'b1; sel = start_sel; cancel = cancel0;
        @(posedge clk); #1;
        for (int c = 1; c <= exp_q.size(); c++) begin
            checks++;
            if (observed() !== exp_q[c-1]) begin
                errors++;
                $display("FAIL %s cycle %0d: got st/valves/secs/b/d/a/bs=%b want %b",
                         name, c, observed(), exp_q[c-1]);
            end
            @(negedge clk);
            start  = (c == restart_at);
            sel    = (c == restart_at) ? restart_sel : (scramble ? 4'($urandom) : start_sel);
            cancel = (c == cancel_at);
            @(posedge clk); #1;
        end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; sel = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cancel = 1'b0; sel = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", observed(), 15'd0);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (observed() !== 15'd0) begin
            errors++;
            $display("FAIL after_reset_idle: got %b want %b", observed(), 15'd0);
        end
    endtask

    task automatic test_bad_sel();
        logic [3:0] codes[$];
        logic [3:0] v;
        codes.push_back(4'b0011);
        codes.push_back(4'b0000);
        while (codes.size() < 6) begin
            v = 4'($urandom_range(0, 15));
            if ($countones(v) != 1) codes.push_back(v);
        end
        foreach (codes[n]) begin
            @(negedge clk); start = 1'b1; sel = codes[n];
            @(posedge clk); #1;
            checks++;
            if (observed() !== pack(0, 0, 0, 0, 0, 0, 1)) begin
                errors++;
                $display("FAIL bad_sel %b pulse: got %b want %b", codes[n], observed(), pack(0, 0, 0, 0, 0, 0, 1));
            end
            @(negedge clk); start = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (observed() !== 15'd0) begin
                errors++;
                $display("FAIL bad_sel %b clear: got %b want %b", codes[n], observed(), 15'd0);
            end
        end
    endtask

    task automatic test_cancel_idle();
        @(negedge clk); cancel = 1'b1; sel = SEL_ANY();
        @(posedge clk); #1;
        checks++;
        if (observed() !== 15'd0) begin
            errors++;
            $display("FAIL cancel_idle: got %b want %b", observed(), 15'd0);
        end
        @(negedge clk); cancel = 1'b0;
    endtask

    function automatic logic [3:0] SEL_ANY();
        return 4'b0001;
    endfunction

    task automatic test_reset_mid();
        @(negedge clk); start = 1'b1; sel = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); start = 1'b0;
        end
        #4;
        checks++;
        if (observed() !== pack(2, 2, 2, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid pre: got %b want %b", observed(), pack(2, 2, 2, 1, 0, 0, 0));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (observed() !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %b want %b", observed(), 15'd0);
        end
        @(negedge clk); reset = 1'b0; start = 1'b1; sel = 4'b0001;
        @(posedge clk); #1;
        checks++;
        if (observed() !== pack(1, 1, 2, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid restart: got %b want %b", observed(), pack(1, 1, 2, 1, 0, 0, 0));
        end
        @(negedge clk); start = 1'b0;
        repeat (TPS * 5 + 2) @(posedge clk);
    endtask

    task automatic test_random();
        logic [3:0] codes [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int n = 0; n < 40; n++) begin
            int ri   = int'($urandom_range(0, 3));
            int tot  = total_cycles(ri);
            int cat  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, tot + 1)) : 0;
            int rat  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, tot + 1)) : 0;
            bit c0   = 1'($urandom_range(0, 1));
            if (cat != 0 && cat <= tot && rat > cat) rat = 0;
            run_recipe("random", ri, codes[ri], cat, c0, rat, 4'($urandom), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        run_recipe("espresso", 0, 4'b0001, 0, 1'b0, 0, 4'b0000, 1'b0);
        run_recipe("chocolate", 2, 4'b0100, 0, 1'b0, 0, 4'b0000, 1'b0);
        run_recipe("latte_cancel", 1, 4'b0010, 6, 1'b0, 0, 4'b0000, 1'b0);
        run_recipe("mocca_restart", 3, 4'b1000, 0, 1'b0, 3, 4'b0001, 1'b0);
        run_recipe("cancel_with_start", 1, 4'b0010, 0, 1'b1, 0, 4'b0000, 1'b0);
        run_recipe("cancel_in_done", 0, 4'b0001, 21, 1'b0, 0, 4'b0000, 1'b0);
        test_bad_sel();
        test_cancel_idle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
